// File: rtl/t_flip_flop_if.sv
// Toggle-bank bus: per-bit toggle requests in, stored state and its complement out.
interface t_flip_flop_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] T;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qbar;

    modport master (
        output T,
        input  Q,
        input  Qbar
    );

    modport slave (
        input  T,
        output Q,
        output Qbar
    );
endinterface

// File: rtl/t_flip_flop.sv
// WIDTH-bit bank of independent T flip-flops with synchronous active-high reset.
// Q comes straight from the state register; Qbar is its combinational complement.
module t_flip_flop #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic         Clk,
    input  logic         Rst,
    t_flip_flop_if.slave bus
);

    // Power-up value matches the reset value so Q is defined before any reset.
    logic [WIDTH-1:0] q_q = RESET_VAL;
    logic [WIDTH-1:0] q_d;

    // Next state: each bit flips where its toggle request is set.
    always_comb begin
        q_d = q_q ^ bus.T;
    end

    // State register; reset has priority and masks T on the same edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.Qbar = ~q_q;

endmodule

// File: tb/tb_t_flip_flop.sv
// Directed bench for t_flip_flop: a 1-bit bank with reset value 0 and a 4-bit bank with reset value 4'b1010.
module tb_t_flip_flop;

    logic Clk;
    logic Rst1;
    logic Rst4;
    int   checks;
    int   errors;

    t_flip_flop_if #(.WIDTH(1)) bus1 ();
    t_flip_flop_if #(.WIDTH(4)) bus4 ();

    t_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
        .Clk (Clk),
        .Rst (Rst1),
        .bus (bus1.slave)
    );

    t_flip_flop #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (
        .Clk (Clk),
        .Rst (Rst4),
        .bus (bus4.slave)
    );

    // Clock starts high; rising edges at 20, 40, 60 ... ns.
    initial begin
        Clk = 1'b1;
        forever #10 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to 5 ns past the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #5;
    endtask

    task automatic check1(input string tag, input logic exp_q);
        check({tag, "_q"},    {3'b000, bus1.Q},    {3'b000, exp_q});
        check({tag, "_qbar"}, {3'b000, bus1.Qbar}, {3'b000, ~exp_q});
    endtask

    initial begin
        logic [4:0] toggle_seq;
        checks  = 0;
        errors  = 0;
        Rst1    = 1'b0;
        Rst4    = 1'b0;
        bus1.T  = 1'b0;
        bus4.T  = 4'b0000;
        toggle_seq = 5'b10101;

        // Power-up state before any edge.
        #1;
        check1("powerup", 1'b0);
        check("powerup4_q",    bus4.Q,    4'b1010);
        check("powerup4_qbar", bus4.Qbar, 4'b0101);
        #4;

        // Hold with T=0 for 5 edges (100 ns).
        for (int i = 0; i < 5; i++) begin
            tick();
            check1("hold0", 1'b0);
        end

        // T=1 for 5 edges: 1,0,1,0,1.
        bus1.T = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check1("toggle", toggle_seq[4 - i]);
        end

        // T=0: hold at 1.
        bus1.T = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("hold1", 1'b1);
        end

        // Reset mid-toggle with T=1, then resume toggling.
        bus1.T = 1'b1;
        Rst1   = 1'b1;
        tick();
        check1("rst_mid", 1'b0);
        Rst1 = 1'b0;
        tick();
        check1("resume", 1'b1);

        // Rst and T together for 3 edges: reset wins.
        Rst1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("rst_wins", 1'b0);
        end
        Rst1   = 1'b0;
        bus1.T = 1'b0;
        tick();
        check1("after_rst", 1'b0);

        // T pulsed between edges only: no effect.
        bus1.T = 1'b1;
        #10;
        bus1.T = 1'b0;
        tick();
        check1("t_between", 1'b0);

        // Move to Q=1, then pulse Rst between edges: no effect.
        bus1.T = 1'b1;
        tick();
        check1("set1", 1'b1);
        bus1.T = 1'b0;
        Rst1   = 1'b1;
        #10;
        Rst1 = 1'b0;
        tick();
        check1("rst_between", 1'b1);

        // 4-bit bank: reset, then T=0110 -> 1100, then T=1111 -> 0011.
        Rst4   = 1'b1;
        bus4.T = 4'b1111;
        tick();
        check("w4_rst_q",    bus4.Q,    4'b1010);
        check("w4_rst_qbar", bus4.Qbar, 4'b0101);
        Rst4   = 1'b0;
        bus4.T = 4'b0110;
        tick();
        check("w4_t0110_q",    bus4.Q,    4'b1100);
        check("w4_t0110_qbar", bus4.Qbar, 4'b0011);
        bus4.T = 4'b1111;
        tick();
        check("w4_t1111_q",    bus4.Q,    4'b0011);
        check("w4_t1111_qbar", bus4.Qbar, 4'b1100);
        bus4.T = 4'b0000;
        tick();
        check("w4_hold_q", bus4.Q, 4'b0011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
